lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the memory address width (allowed range 16..32).
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles to wait for mem_ack (minimum 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  4  operation: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all other codes are illegal.
REQ-008 req_base  input  32  base register value.
REQ-009 req_offset  input  16  signed offset.
REQ-010 req_wdata  input  32  store source register value.
REQ-011 req_rd  input  5  load destination register.
REQ-012 mem_en  output  1  bus request, held until ack or timeout.
REQ-013 mem_we  output  1  write strobe.
REQ-014 mem_sel  output  4  byte-lane enables, little-endian (lane 0 = bits 7:0).
REQ-015 mem_addr  output  ADDR_W  word-aligned address; bits 1:0 are always 0.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_ack  input  1  bus completion; sampled only in ACCESS.
REQ-018 mem_rdata  input  32  read word; valid when mem_ack is 1.
REQ-019 resp_valid  output  1  one-cycle completion pulse.
REQ-020 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-021 resp_rd  output  5  echo of req_rd.
REQ-022 resp_wen  output  1  register write enable; 1 only for an error-free load.
REQ-023 resp_err  output  2  completion status: 00 ok, 01 misaligned, 10 timeout, 11 illegal op.

Function
REQ-024 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-025 Effective address SHALL be req_base + sign-extended req_offset, mod 2^32, computed in the IDLE accept cycle; mem_addr SHALL be {ea[ADDR_W-1:2],2'b00}.
REQ-026 IDLE + req_valid with an illegal op SHALL go to RESP with err=11 and no bus access.
REQ-027 IDLE + req_valid with a misaligned address SHALL go to RESP with err=01 and no bus access; misaligned means ea[0]!=0 for LH/LHU/SH, or ea[1:0]!=0 for LW/SW.
REQ-028 IDLE + req_valid with a legal, aligned request SHALL register the request and enter ACCESS; mem_en=1 from the next cycle.
REQ-029 In ACCESS, mem_en, mem_we, mem_sel, mem_addr and mem_wdata SHALL be held stable until exit.
REQ-030 Store lanes: SB sel=0001<<ea[1:0], wdata={4{wdata[7:0]}}; SH sel=0011 (ea[1]=0) or 1100, wdata={2{wdata[15:0]}}; SW sel=1111, wdata=req_wdata.
REQ-031 Loads SHALL drive mem_we=0 and mem_sel=1111.
REQ-032 An ACCESS wait counter SHALL be cleared on ACCESS entry and increment each ACCESS cycle without mem_ack.
REQ-033 mem_ack in ACCESS SHALL capture mem_rdata and go to RESP with err=00; mem_ack on the same cycle the counter hits TIMEOUT-1 SHALL count as success.
REQ-034 If the counter reaches TIMEOUT-1 with no ack, the block SHALL go to RESP with err=10 and deassert mem_en the next cycle; a late ack SHALL be ignored.
REQ-035 Load extraction SHALL select the byte or halfword by ea[1:0] or ea[1], sign-extend it for LB/LH, and zero-extend it for LBU/LHU; LW SHALL return the word unmodified.
REQ-036 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; resp_* SHALL otherwise be 0.
REQ-037 Latency SHALL be: accept at cycle 0, mem_en at cycle 1, ack at cycle k, resp_valid at cycle k+1; error responses SHALL appear at cycle 1.
REQ-038 A req_valid presented outside IDLE SHALL be ignored (not accepted), because req_ready=0.
REQ-039 Back-to-back throughput SHALL be one request per (access cycles + 2).

Reset
REQ-040 rst=0 SHALL asynchronously force state to IDLE, clear the counter, clear registered request fields, and drive all outputs to 0 except req_ready=1.
REQ-041 A reset during ACCESS SHALL drop mem_en immediately, discard the pending request, and produce no resp_valid.
REQ-042 After rst deasserts, the first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-043 LB with base=0x100, off=-1 (ea=0xFF), mem_rdata=0x80FF_FF7F, ack at cycle 2 -> mem_addr=0xFC, sel=1111; resp at cycle 3 with rdata=0xFFFF_FF80, wen=1, err=00.
REQ-044 SH with ea=0x202, wdata=0x1234_ABCD -> mem_we=1, sel=1100, mem_wdata=0xABCD_ABCD, resp err=00, wen=0, rdata=0.
REQ-045 LW with ea=0x301 -> no mem_en ever asserted; resp at cycle 1 with err=01, wen=0.
REQ-046 LHU with TIMEOUT=4 and no ack -> mem_en high for 4 cycles; resp err=10; a late ack afterwards is ignored.
REQ-047 req_op=0011 -> resp err=11 at cycle 1, no bus access.
REQ-048 SW with ack withheld and rst pulsed low in ACCESS -> mem_en=0 immediately, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes a register-based memory request, drives a
// single-beat word bus with byte-lane enables and returns extended load data.
module lsu_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_base,
  input  logic [15:0]       req_offset,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_wen,
  output logic [1:0]        resp_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_OP    = 2'b11;

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_misaligned = lo[0];
      OP_LW, OP_SW:         op_misaligned = (lo != 2'b00);
      default:              op_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = word >> {lo, 3'b000};
    half    = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_extract = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_extract = {24'h000000, shifted[7:0]};
      OP_LH:   load_extract = {{16{half[15]}}, half};
      OP_LHU:  load_extract = {16'h0000, half};
      OP_LW:   load_extract = word;
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [3:0]        op_r;
  logic [1:0]        lo_r;
  logic [4:0]        rd_r;
  logic              req_ready_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [3:0]        mem_sel_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic [4:0]        resp_rd_r;
  logic              resp_wen_r;
  logic [1:0]        resp_err_r;

  logic [31:0]       ea_s;
  logic              store_s;
  logic [3:0]        sel_s;
  logic [31:0]       wdata_s;

  // Accept-cycle decode: effective address, lane enables and replicated store data.
  always_comb begin
    ea_s    = req_base + {{16{req_offset[15]}}, req_offset};
    store_s = 1'b0;
    sel_s   = 4'b1111;
    wdata_s = 32'h0000_0000;
    case (req_op)
      OP_SB: begin
        store_s = 1'b1;
        sel_s   = 4'b0001 << ea_s[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        store_s = 1'b1;
        sel_s   = ea_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{req_wdata[15:0]}};
      end
      OP_SW: begin
        store_s = 1'b1;
        sel_s   = 4'b1111;
        wdata_s = req_wdata;
      end
      default: begin
        store_s = 1'b0;
        sel_s   = 4'b1111;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Request FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      op_r         <= 4'b0000;
      lo_r         <= 2'b00;
      rd_r         <= 5'd0;
      req_ready_r  <= 1'b1;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_sel_r    <= 4'b0000;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_rd_r    <= 5'd0;
      resp_wen_r   <= 1'b0;
      resp_err_r   <= ERR_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            if (!op_legal(req_op) || op_misaligned(req_op, ea_s[1:0])) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_rd_r    <= req_rd;
              resp_err_r   <= op_legal(req_op) ? ERR_ALIGN : ERR_OP;
            end else begin
              state_r     <= ST_ACCESS;
              cnt_r       <= '0;
              op_r        <= req_op;
              lo_r        <= ea_s[1:0];
              rd_r        <= req_rd;
              mem_en_r    <= 1'b1;
              mem_we_r    <= store_s;
              mem_sel_r   <= sel_s;
              mem_addr_r  <= {ea_s[ADDR_W-1:2], 2'b00};
              mem_wdata_r <= wdata_s;
            end
          end
        end
        ST_ACCESS: begin
          // An ack arriving on the final wait cycle still wins over the timeout.
          if (mem_ack || (cnt_r == CNT_LAST)) begin
            state_r      <= ST_RESP;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_sel_r    <= 4'b0000;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b1;
            resp_rd_r    <= rd_r;
            resp_err_r   <= mem_ack ? ERR_OK : ERR_TMO;
            resp_wen_r   <= mem_ack & ~mem_we_r;
            resp_rdata_r <= (mem_ack && !mem_we_r) ? load_extract(op_r, lo_r, mem_rdata)
                                                   : 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          resp_rd_r    <= 5'd0;
          resp_wen_r   <= 1'b0;
          resp_err_r   <= ERR_OK;
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          mem_en_r     <= 1'b0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_sel    = mem_sel_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_rd    = resp_rd_r;
  assign resp_wen   = resp_wen_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: each transaction is predicted from the
// address/size arithmetic of the request and checked cycle by cycle.
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_base, req_wdata;
  logic [15:0] req_offset;
  logic [4:0]  req_rd;
  logic        mem_en, mem_we, mem_ack;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_wen;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;

  int n_chk = 0;
  int n_err = 0;

  lsu_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_en(mem_en), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_wen(resp_wen),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes; 0 marks an illegal opcode.
  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100, 4'b1000: return 1;
      4'b0001, 4'b0101, 4'b1001: return 2;
      4'b0010, 4'b1010:          return 4;
      default:                   return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return op inside {4'b1000, 4'b1001, 4'b1010};
  endfunction

  function automatic bit op_signed(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001};
  endfunction

  // One request from the IDLE cycle through the return to IDLE; starts and ends at a negedge.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                         input logic [31:0] wd, input logic [4:0] rd, input int ack_at,
                         input logic [31:0] rword);
    int          nb, lane, n_acc;
    logic [31:0] ea, e_sel, e_wdata, e_rdata;
    logic [1:0]  e_err;
    longint      v;
    nb   = op_bytes(op);
    ea   = base + {{16{off[15]}}, off};
    lane = int'(ea % 32'd4);
    n_acc = 0;
    if (nb == 0) e_err = 2'b11;
    else if ((ea % nb) != 0) e_err = 2'b01;
    else if (ack_at >= 1 && ack_at <= TO) begin e_err = 2'b00; n_acc = ack_at; end
    else begin e_err = 2'b10; n_acc = TO; end

    e_sel = op_store(op) ? (((32'd1 << nb) - 32'd1) << lane) : 32'hF;
    if (nb == 1)      e_wdata = (wd & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) e_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    else              e_wdata = wd;
    v = (longint'(rword) >> (8 * lane)) & ((64'd1 << (8 * nb)) - 1);
    if (op_signed(op) && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    e_rdata = (e_err == 2'b00 && !op_store(op)) ? 32'(v) : 32'h0;

    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_base = base; req_offset = off;
    req_wdata = wd; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    // A request offered while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1)); req_op = 4'($urandom);
    req_base = $urandom; req_offset = 16'($urandom); req_rd = 5'($urandom);
    for (int c = 1; c <= n_acc; c++) begin
      chk("acc_en", {31'd0, mem_en}, 32'd1);
      chk("acc_we", {31'd0, mem_we}, {31'd0, op_store(op)});
      chk("acc_sel", {28'd0, mem_sel}, e_sel);
      chk("acc_addr", mem_addr, ea - (ea % 32'd4));
      if (op_store(op)) chk("acc_wdata", mem_wdata, e_wdata);
      chk("acc_busy", {30'd0, req_ready, resp_valid}, 32'd0);
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? rword : $urandom;
      @(negedge clk);
    end
    mem_ack   = (ack_at == n_acc + 1) && (n_acc > 0);
    mem_rdata = $urandom;
    chk("resp_en", {31'd0, mem_en}, 32'd0);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_err", {30'd0, resp_err}, {30'd0, e_err});
    chk("resp_wen", {31'd0, resp_wen}, {31'd0, (e_err == 2'b00) && !op_store(op)});
    chk("resp_rdata", resp_rdata, e_rdata);
    chk("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
    chk("resp_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0; req_valid = 1'b0;
    chk("after_valid", {31'd0, resp_valid}, 32'd0);
    chk("after_out", {resp_rdata[29:0], resp_err}, 32'd0);
    chk("after_en", {31'd0, mem_en}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_base = 32'd0; req_offset = 16'd0;
    req_wdata = 32'd0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem", {mem_en, mem_we, mem_sel, mem_addr[25:0]} | mem_wdata, 32'd0);
    chk("rst_resp", {resp_valid, resp_wen, resp_err, resp_rd, resp_rdata[22:0]}, 32'd0);
    rst = 1'b1;

    run_txn(4'b0000, 32'h100, 16'hFFFF, 32'h0, 5'd3, 2, 32'h80FF_FF7F);
    run_txn(4'b1001, 32'h200, 16'h0002, 32'h1234_ABCD, 5'd4, 1, 32'h0);
    run_txn(4'b0010, 32'h300, 16'h0001, 32'h0, 5'd5, 1, 32'hDEAD_BEEF);
    run_txn(4'b0101, 32'h400, 16'h0000, 32'h0, 5'd6, TO + 1, 32'hCAFE_F00D);
    run_txn(4'b0011, 32'h500, 16'h0000, 32'h0, 5'd7, 1, 32'h0);
    run_txn(4'b1000, 32'h603, 16'h0000, 32'h0000_00A5, 5'd8, TO, 32'h0);

    // Reset pulsed while a store waits for its ack.
    req_valid = 1'b1; req_op = 4'b1010; req_base = 32'h700; req_offset = 16'd0;
    req_wdata = 32'h5555_AAAA; req_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstacc_en_before", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstacc_en", {31'd0, mem_en}, 32'd0);
    chk("rstacc_ready", {31'd0, req_ready}, 32'd1);
    chk("rstacc_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstacc_noresp", {30'd0, resp_valid, mem_en}, 32'd0);
    end

    for (int t = 0; t < 150; t++) begin
      logic [3:0] op;
      if ($urandom_range(0, 3) == 0) op = 4'($urandom);
      else begin
        case ($urandom_range(0, 7))
          0: op = 4'b0000; 1: op = 4'b0001; 2: op = 4'b0010; 3: op = 4'b0100;
          4: op = 4'b0101; 5: op = 4'b1000; 6: op = 4'b1001; default: op = 4'b1010;
        endcase
      end
      run_txn(op, $urandom, 16'($urandom), $urandom, 5'($urandom),
              $urandom_range(1, TO + 1), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
